// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and position helpers, reused by the sync
// generator and by downstream pixel-fetch logic.
package vga_timing_pkg;

    localparam int COUNT_W = 10;

    typedef logic [COUNT_W-1:0] pos_t;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // True when p lies in [lo, lo+len-1]; done in int so a zero lower bound
    // does not turn into an always-true unsigned compare.
    function automatic logic in_span(input pos_t p, input int lo, input int len);
        return (int'(p) >= lo) && (int'(p) < lo + len);
    endfunction

endpackage

// File: rtl/hvsync_generator.sv
// Horizontal/vertical raster counters with registered sync outputs that are
// decoded from the next-state counters so they line up with hpos/vpos.
module hvsync_generator
    import vga_timing_pkg::*;
#(
    parameter int   H_DISPLAY   = DEF_H_DISPLAY,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_DISPLAY   = DEF_V_DISPLAY,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             display_on,
    output logic [COUNT_W-1:0] hpos,
    output logic [COUNT_W-1:0] vpos
);

    localparam int   LINE_CLKS   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int   FRAME_LINES = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam pos_t H_LAST      = pos_t'(LINE_CLKS - 1);
    localparam pos_t V_LAST      = pos_t'(FRAME_LINES - 1);
    localparam int   HS_START    = H_DISPLAY + H_FRONT;
    localparam int   VS_START    = V_DISPLAY + V_FRONT;

    pos_t hpos_q, hpos_d;
    pos_t vpos_q, vpos_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic line_end;

    always_comb begin
        line_end = (hpos_q == H_LAST);
        hpos_d   = line_end ? '0 : hpos_q + pos_t'(1);
        vpos_d   = vpos_q;
        if (line_end) begin
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + pos_t'(1);
        end
    end

    // Decoding the _d values means the registered sync lands on the same
    // edge as the counter value it belongs to.
    always_comb begin
        hsync_d = in_span(hpos_d, HS_START, H_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = in_span(vpos_d, VS_START, V_SYNC) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q  <= '0;
            vpos_q  <= '0;
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
        end else begin
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = (hpos_q < pos_t'(H_DISPLAY)) && (vpos_q < pos_t'(V_DISPLAY));

endmodule

// File: tb/tb_hvsync_generator.sv
// Bench for hvsync_generator: default VGA timing plus two shrunken timings
// (one active-high) so whole frames fit in a short run.
module tb_hvsync_generator;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // default 640x480 timing
    logic       d_hs, d_vs, d_de;
    logic [9:0] d_hp, d_vp;
    // small timing, active-low: line 19 clocks, frame 12 lines
    localparam int SHD = 10, SHF = 2, SHS = 3, SHB = 4;
    localparam int SVD = 6,  SVF = 1, SVS = 2, SVB = 3;
    localparam int S_HT = SHD + SHF + SHS + SHB;
    localparam int S_FT = S_HT * (SVD + SVF + SVS + SVB);
    logic       s_hs, s_vs, s_de;
    logic [9:0] s_hp, s_vp;
    // small timing, active-high sync
    localparam int PHD = 8, PHF = 1, PHS = 2, PHB = 1;
    localparam int PVD = 5, PVF = 2, PVS = 1, PVB = 2;
    logic       p_hs, p_vs, p_de;
    logic [9:0] p_hp, p_vp;

    hvsync_generator u_dflt (
        .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs),
        .display_on(d_de), .hpos(d_hp), .vpos(d_vp)
    );

    hvsync_generator #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .SYNC_ACTIVE(1'b0)
    ) u_small (
        .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs),
        .display_on(s_de), .hpos(s_hp), .vpos(s_vp)
    );

    hvsync_generator #(
        .H_DISPLAY(PHD), .H_FRONT(PHF), .H_SYNC(PHS), .H_BACK(PHB),
        .V_DISPLAY(PVD), .V_FRONT(PVF), .V_SYNC(PVS), .V_BACK(PVB),
        .SYNC_ACTIVE(1'b1)
    ) u_pos (
        .clk(clk), .reset(reset), .hsync(p_hs), .vsync(p_vs),
        .display_on(p_de), .hpos(p_hp), .vpos(p_vp)
    );

    int nvec = 0;
    int nerr = 0;
    int t    = 0;   // rising edges since reset released

    int h_low = 0, h_first = -1;
    int s_de_cnt = 0, s_vs_low = 0, s_vs_first_h = -1, s_vs_first_v = -1;
    bit tally = 1'b1;

    task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0d got %0d expected %0d", nm, t, act, exp);
        end
    endtask

    // Reference: position follows directly from elapsed clocks.
    task automatic check_model(input string nm, input int tt,
                               input int hd, input int hf, input int hs, input int hb,
                               input int vd, input int vf, input int vs, input int vb,
                               input logic act,
                               input logic [9:0] hp, input logic [9:0] vp,
                               input logic ahs, input logic avs, input logic ade);
        int ht, vt, eh, ev;
        logic ehs, evs, ede;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        eh  = tt % ht;
        ev  = (tt / ht) % vt;
        ehs = (eh >= hd + hf && eh < hd + hf + hs) ? act : ~act;
        evs = (ev >= vd + vf && ev < vd + vf + vs) ? act : ~act;
        ede = (eh < hd) && (ev < vd);
        cmp({nm, ".hpos"}, hp, 10'(eh));
        cmp({nm, ".vpos"}, vp, 10'(ev));
        cmp({nm, ".hsync"}, {9'd0, ahs}, {9'd0, ehs});
        cmp({nm, ".vsync"}, {9'd0, avs}, {9'd0, evs});
        cmp({nm, ".display_on"}, {9'd0, ade}, {9'd0, ede});
    endtask

    task automatic check_all();
        check_model("dflt", t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, d_hp, d_vp, d_hs, d_vs, d_de);
        check_model("small", t, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB, 1'b0, s_hp, s_vp, s_hs, s_vs, s_de);
        check_model("pos", t, PHD, PHF, PHS, PHB, PVD, PVF, PVS, PVB, 1'b1, p_hp, p_vp, p_hs, p_vs, p_de);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        t++;
        check_all();
        if (tally) begin
            if (t >= 1 && t <= 800 && d_hs == 1'b0) begin
                if (h_first < 0) h_first = int'(d_hp);
                h_low++;
            end
            if (t >= S_FT && t < 2 * S_FT) begin
                if (s_de) s_de_cnt++;
                if (!s_vs) begin
                    if (s_vs_first_h < 0) begin
                        s_vs_first_h = int'(s_hp);
                        s_vs_first_v = int'(s_vp);
                    end
                    s_vs_low++;
                end
            end
        end
    endtask

    task automatic check_reset_state(input string nm);
        cmp({nm, ".hpos"}, d_hp, 10'd0);
        cmp({nm, ".vpos"}, d_vp, 10'd0);
        cmp({nm, ".hsync"}, {9'd0, d_hs}, 10'd1);
        cmp({nm, ".vsync"}, {9'd0, d_vs}, 10'd1);
        cmp({nm, ".display_on"}, {9'd0, d_de}, 10'd1);
        cmp({nm, ".pos_hsync"}, {9'd0, p_hs}, 10'd0);
        cmp({nm, ".small_hpos"}, s_hp, 10'd0);
    endtask

    // Assert reset between edges, check it takes effect at once and holds
    // across a clock edge, then release on a falling edge.
    task automatic async_reset(input int offset);
        #(offset);
        reset = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        @(negedge clk);
        reset = 1'b0;
        t = 0;
    endtask

    typedef struct {
        int         t;
        logic [9:0] hp;
        logic [9:0] vp;
        logic       hs;
        logic       de;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs = '{
            '{1,   10'd1,   10'd0, 1'b1, 1'b1},
            '{639, 10'd639, 10'd0, 1'b1, 1'b1},
            '{640, 10'd640, 10'd0, 1'b1, 1'b0},
            '{655, 10'd655, 10'd0, 1'b1, 1'b0},
            '{656, 10'd656, 10'd0, 1'b0, 1'b0},
            '{751, 10'd751, 10'd0, 1'b0, 1'b0},
            '{752, 10'd752, 10'd0, 1'b1, 1'b0},
            '{799, 10'd799, 10'd0, 1'b1, 1'b0},
            '{800, 10'd0,   10'd1, 1'b1, 1'b1}
        };

        reset = 1'b1;
        #2;
        check_reset_state("reset");
        repeat (2) @(negedge clk);
        check_reset_state("reset_clk");
        reset = 1'b0;
        t = 0;

        foreach (vecs[i]) begin
            while (t < vecs[i].t) tick();
            cmp($sformatf("vec%0d.hpos", i), d_hp, vecs[i].hp);
            cmp($sformatf("vec%0d.vpos", i), d_vp, vecs[i].vp);
            cmp($sformatf("vec%0d.hsync", i), {9'd0, d_hs}, {9'd0, vecs[i].hs});
            cmp($sformatf("vec%0d.display_on", i), {9'd0, d_de}, {9'd0, vecs[i].de});
        end
        tally = 1'b0;

        cmp("hsync_low_clocks", 10'(h_low), 10'd96);
        cmp("hsync_first_hpos", 10'(h_first), 10'd656);
        cmp("small_display_clocks", 10'(s_de_cnt), 10'(SHD * SVD));
        cmp("small_vsync_low_clocks", 10'(s_vs_low), 10'(SVS * S_HT));
        cmp("small_vsync_first_hpos", 10'(s_vs_first_h), 10'd0);
        cmp("small_vsync_first_vpos", 10'(s_vs_first_v), 10'(SVD + SVF));

        // mid-line reset on the default timing at hpos=300 of line 1
        while (t % 800 != 300) tick();
        cmp("pre_rst.hpos", d_hp, 10'd300);
        async_reset(2);
        tick();
        cmp("resume.hpos", d_hp, 10'd1);
        cmp("resume.vpos", d_vp, 10'd0);

        // random run lengths with randomly placed asynchronous resets
        for (int k = 0; k < 6; k++) begin
            int n;
            n = int'($urandom_range(50, 500));
            repeat (n) tick();
            async_reset(int'($urandom_range(1, 4)));
        end
        repeat (600) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
